// File: rtl/score_pkg.sv
// Shared constants for the score path: default widths/limits, game state encoding,
// and the 7-segment glyphs used by the display decoder that consumes the score.
package score_pkg;

    localparam int SCORE_W   = 10;
    localparam int MAX_SCORE = 999;
    localparam int COMBO_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        ADD  = 2'd2,
        OVER = 2'd3
    } state_e;

    // Segment order {g,f,e,d,c,b,a}, active high, indexed by decimal digit.
    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

// File: rtl/combo_timer.sv
// Combo multiplier with its expiry window: a scoring hit raises the multiplier and
// re-arms the window, a miss or an expired window drops it back to 1.
module combo_timer #(
    parameter int COMBO_MAX    = score_pkg::COMBO_MAX,
    parameter int COMBO_WINDOW = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       hit_acc,
    input  logic       hit_zero,
    input  logic       active,
    output logic [2:0] combo
);
    import score_pkg::*;

    localparam int               CNT_W  = $clog2(COMBO_WINDOW + 1);
    localparam logic [CNT_W-1:0] WINDOW = CNT_W'(COMBO_WINDOW);
    localparam logic [2:0]       CMAX   = 3'(COMBO_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       combo_q, combo_d;

    always_comb begin
        cnt_d   = cnt_q;
        combo_d = combo_q;
        if (clear) begin
            cnt_d   = '0;
            combo_d = 3'd1;
        end else if (hit_acc) begin
            // An accepted hit takes priority over a window expiring in the same cycle.
            if (hit_zero) begin
                cnt_d   = '0;
                combo_d = 3'd1;
            end else begin
                cnt_d   = WINDOW;
                combo_d = (combo_q >= CMAX) ? CMAX : combo_q + 3'd1;
            end
        end else if (active && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                combo_d = 3'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            combo_q <= 3'd1;
        end else begin
            cnt_q   <= cnt_d;
            combo_q <= combo_d;
        end
    end

    assign combo = combo_q;

endmodule

// File: rtl/score_counter.sv
// Game score accumulator: handshaked hits scaled by the combo, saturated at MAX_SCORE.
// Optional best-score tracking is enabled by defining HIGH_SCORE_EN.
module score_counter #(
    parameter int SCORE_W      = score_pkg::SCORE_W,
    parameter int MAX_SCORE    = score_pkg::MAX_SCORE,
    parameter int COMBO_MAX    = score_pkg::COMBO_MAX,
    parameter int COMBO_WINDOW = 25000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               game_over,
    input  logic               hit_valid,
    input  logic [3:0]         hit_points,
    output logic               hit_ready,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         combo,
    output logic               playing,
    output logic               score_changed,
    output logic [SCORE_W-1:0] high_score
);
    import score_pkg::*;

    localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W + 1)'(MAX_SCORE);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [6:0]         b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W + 1)'(b);
        return (sum > MAX_EXT) ? MAX_EXT[SCORE_W-1:0] : sum[SCORE_W-1:0];
    endfunction

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [6:0]         product_q, product_d;
    logic               changed_q, changed_d;
    logic               in_game;
    logic               accept;

    assign in_game   = (state_q == PLAY) || (state_q == ADD);
    assign hit_ready = (state_q == PLAY) && !start && !game_over;
    assign accept    = hit_valid && hit_ready;

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        product_d = product_q;
        if (start) begin
            state_d   = PLAY;
            score_d   = '0;
            product_d = '0;
        end else begin
            // A pending add still lands even if game_over arrives during ADD.
            if (state_q == ADD) begin
                score_d = sat_add(score_q, product_q);
            end
            if (accept) begin
                product_d = 7'(hit_points) * 7'(combo);
            end
            if (game_over && in_game) begin
                state_d = OVER;
            end else if (accept) begin
                state_d = ADD;
            end else if (state_q == ADD) begin
                state_d = PLAY;
            end
        end
    end

    assign changed_d = (score_d != score_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            score_q   <= '0;
            product_q <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            product_q <= product_d;
            changed_q <= changed_d;
        end
    end

    combo_timer #(
        .COMBO_MAX    (COMBO_MAX),
        .COMBO_WINDOW (COMBO_WINDOW)
    ) u_combo_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (start),
        .hit_acc  (accept),
        .hit_zero (hit_points == 4'd0),
        .active   (in_game),
        .combo    (combo)
    );

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_q, high_d;

    always_comb begin
        high_d = high_q;
        if (state_d == OVER && state_q != OVER && score_d > high_q) begin
            high_d = score_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            high_q <= '0;
        end else begin
            high_q <= high_d;
        end
    end

    assign high_score = high_q;
`else
    assign high_score = '0;
`endif

    assign score         = score_q;
    assign playing       = in_game;
    assign score_changed = changed_q;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: directed scenarios pinned by literal values plus a random
// phase, all checked every cycle against a behavioural game model.
module tb_score_counter;

    localparam int SW   = 10;
    localparam int MAXS = 999;
    localparam int CMAX = 4;
    localparam int WIN  = 8;

    logic          clock = 1'b0;
    logic          reset, start, game_over, hit_valid;
    logic [3:0]    hit_points;
    logic          hit_ready, playing, score_changed;
    logic [SW-1:0] score, high_score;
    logic [2:0]    combo;

    score_counter #(
        .SCORE_W      (SW),
        .MAX_SCORE    (MAXS),
        .COMBO_MAX    (CMAX),
        .COMBO_WINDOW (WIN)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .game_over     (game_over),
        .hit_valid     (hit_valid),
        .hit_points    (hit_points),
        .hit_ready     (hit_ready),
        .score         (score),
        .combo         (combo),
        .playing       (playing),
        .score_changed (score_changed),
        .high_score    (high_score)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: 0 idle, 1 play, 2 add, 3 over
    int m_state, m_score, m_combo, m_timer, m_pending, m_high;
    bit m_changed;
    bit m_valid = 1'b0;

    always @(posedge clock) begin : model
        int old_score, nxt;
        bit acc, live;
        if (reset) begin
            m_state = 0; m_score = 0; m_combo = 1; m_timer = 0;
            m_pending = 0; m_high = 0; m_changed = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            old_score = m_score;
            live = (m_state == 1) || (m_state == 2);
            acc  = hit_valid && (m_state == 1) && !start && !game_over;
            nxt  = m_state;
            if (start) begin
                nxt = 1; m_score = 0; m_combo = 1; m_timer = 0; m_pending = 0;
            end else begin
                if (m_state == 2)
                    m_score = (m_score + m_pending > MAXS) ? MAXS : m_score + m_pending;
                if (acc) begin
                    m_pending = int'(hit_points) * m_combo;
                    if (hit_points == 4'd0) begin
                        m_combo = 1; m_timer = 0;
                    end else begin
                        m_combo = (m_combo + 1 > CMAX) ? CMAX : m_combo + 1;
                        m_timer = WIN;
                    end
                end else if (live && m_timer > 0) begin
                    m_timer--;
                    if (m_timer == 0) m_combo = 1;
                end
                if (game_over && live) nxt = 3;
                else if (acc) nxt = 2;
                else if (m_state == 2) nxt = 1;
            end
`ifdef HIGH_SCORE_EN
            if (nxt == 3 && m_state != 3 && m_score > m_high) m_high = m_score;
`endif
            m_changed = (m_score != old_score);
            m_state = nxt;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("cmp_score", int'(score), m_score);
            check("cmp_combo", int'(combo), m_combo);
            check("cmp_playing", int'(playing), int'((m_state == 1) || (m_state == 2)));
            check("cmp_changed", int'(score_changed), int'(m_changed));
            check("cmp_high", int'(high_score), m_high);
            check("cmp_ready", int'(hit_ready), int'((m_state == 1) && !start && !game_over));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_over();
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
    endtask

    // Offers one hit while in PLAY; returns when its score update is visible.
    task automatic hit(input int pts);
        hit_valid  = 1'b1;
        hit_points = 4'(pts);
        #1;
        check("hit_ready_at_accept", int'(hit_ready), 1);
        tick();
        hit_valid = 1'b0;
        tick();
    endtask

    int exp_s [4] = '{10, 30, 60, 100};
    int exp_c [4] = '{2, 3, 4, 4};
    int dens;

    initial begin
        reset = 1'b1; start = 1'b0; game_over = 1'b0;
        hit_valid = 1'b0; hit_points = 4'd0;
        tick(2);
        reset = 1'b0;
        check("rst_score", int'(score), 0);
        check("rst_combo", int'(combo), 1);
        check("rst_ready", int'(hit_ready), 0);
        check("rst_playing", int'(playing), 0);
        check("rst_high", int'(high_score), 0);

        // single hit
        do_start();
        hit(5);
        check("t1_score", int'(score), 5);
        check("t1_changed", int'(score_changed), 1);
        check("t1_combo", int'(combo), 2);
        tick();
        check("t1_changed_drop", int'(score_changed), 0);

        // combo ramp
        do_start();
        for (int i = 0; i < 4; i++) begin
            hit(10);
            check("t2_score", int'(score), exp_s[i]);
            check("t2_combo", int'(combo), exp_c[i]);
        end

        // saturation
        do_start();
        repeat (66) begin
            hit(15);
            hit(0);
        end
        check("t3_preload", int'(score), 990);
        check("t3_combo1", int'(combo), 1);
        hit(15);
        check("t3_sat", int'(score), 999);
        check("t3_sat_changed", int'(score_changed), 1);
        hit(10);
        check("t3_hold", int'(score), 999);
        check("t3_hold_nochg", int'(score_changed), 0);

        // combo window expiry
        do_start();
        hit(3);
        tick(5);
        check("t4_combo_live", int'(combo), 2);
        tick(2);
        check("t4_combo_expired", int'(combo), 1);
        hit(3);
        check("t4_score", int'(score), 6);

        // hit offered together with game_over
        hit_valid = 1'b1; hit_points = 4'd7; game_over = 1'b1;
        #1;
        check("t5_ready_low", int'(hit_ready), 0);
        tick();
        hit_valid = 1'b0; game_over = 1'b0;
        check("t5_playing", int'(playing), 0);
        check("t5_score", int'(score), 6);
        tick(2);
        check("t5_frozen", int'(score), 6);
        do_start();
        check("t5_restart_score", int'(score), 0);
        check("t5_restart_combo", int'(combo), 1);

        // best score across two games
        hit(10);
        hit(15);
        check("t6_game1", int'(score), 40);
        pulse_over();
        do_start();
        hit(15);
        hit(5);
        check("t6_game2", int'(score), 25);
        pulse_over();
`ifdef HIGH_SCORE_EN
        check("t6_high", int'(high_score), 40);
`else
        check("t6_high", int'(high_score), 0);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_high_reset", int'(high_score), 0);

        // random traffic
        dens = 5;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(1, 9);
            reset      = ($urandom_range(0, 999) == 0);
            start      = ($urandom_range(0, 59) == 0);
            game_over  = ($urandom_range(0, 79) == 0);
            hit_valid  = ($urandom_range(0, 9) < dens);
            hit_points = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            tick();
        end
        reset = 1'b0; start = 1'b0; game_over = 1'b0; hit_valid = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
